// File: rtl/pdec_pkg.sv
// Shared types, constants and helpers for the sequential priority decoder.
// Optional feature macro: PDEC_ERR_CNT_EN (the package itself does not depend on it).
package pdec_pkg;

    localparam int PCODE_W   = 3;
    localparam int NLINES    = 4;
    localparam int PCODE_MAX = 4;

    // One buffered decode result: the "no line active" marker plus the one-hot line.
    typedef struct packed {
        logic              none;
        logic [NLINES:1]   y;
    } pdec_entry_t;

    // FLUSH is entered on reset and holds off input for one cycle afterwards.
    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } pdec_state_t;

    // Codes above PCODE_MAX do not name any request line.
    function automatic logic pdec_is_legal(input logic [PCODE_W-1:0] code);
        return code <= PCODE_W'(PCODE_MAX);
    endfunction

    // Code n selects line n; code 0 means no line is active.
    function automatic pdec_entry_t pdec_decode(input logic [PCODE_W-1:0] code);
        pdec_entry_t e;
        e.none = (code == '0);
        e.y    = '0;
        for (int n = 1; n <= NLINES; n++) begin
            if (code == PCODE_W'(n)) begin
                e.y[n] = 1'b1;
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/pdec_fifo.sv
// Small synchronous FIFO of decode results. DEPTH must be a power of two so the
// pointers wrap naturally. Synchronous active-high reset empties the buffer.
module pdec_fifo
    import pdec_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  pdec_entry_t            din,
    output pdec_entry_t            dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    pdec_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because occupancy gates their use.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; a push and pop on the same edge leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_decoder_seq.sv
// Sequential priority-code decoder: takes 3-bit codes over valid/ready, decodes
// legal ones to a one-hot request vector queued in pdec_fifo, flags illegal ones.
// Optional feature macro: PDEC_ERR_CNT_EN adds a saturating illegal-code counter
// output err_cnt, and err becomes (err_cnt != 0).
module priority_decoder_seq
    import pdec_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PCODE_W-1:0] pcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NLINES:1]    y,
    output logic               y_none,
    output logic               err,
`ifdef PDEC_ERR_CNT_EN
    output logic [7:0]         err_cnt,
`endif
    output logic [7:0]         dec_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    pdec_state_t   state;
    pdec_entry_t   entry;
    pdec_entry_t   head;
    logic [CW-1:0] occ;
    logic          legal;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    assign legal     = pdec_is_legal(pcode);
    assign entry     = pdec_decode(pcode);
    assign in_ready  = (state == RUN) && (occ < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal && !full;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign y         = empty ? '0 : head.y;
    assign y_none    = empty ? 1'b0 : head.none;

    pdec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

    // Control FSM: reset parks in FLUSH, which releases to RUN one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FLUSH;
        end else begin
            case (state)
                FLUSH:   state <= RUN;
                RUN:     state <= RUN;
                default: state <= FLUSH;
            endcase
        end
    end

    // Count of legal codes decoded, wrapping at 256.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (push) begin
            dec_cnt <= dec_cnt + 8'd1;
        end
    end

`ifdef PDEC_ERR_CNT_EN
    // Saturating count of accepted illegal codes; err follows it being non-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && !legal && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err = (err_cnt != '0);
`else
    // Sticky illegal-code flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && !legal) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Directed testbench for priority_decoder_seq (default DEPTH = 2).
// Build with PDEC_ERR_CNT_EN defined to also exercise the err_cnt output.
module tb_priority_decoder_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] pcode;
    logic       out_valid;
    logic       out_ready;
    logic [4:1] y;
    logic       y_none;
    logic       err;
    logic [7:0] dec_cnt;
`ifdef PDEC_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int total;
    int bad;

    typedef struct {
        logic       iv;
        logic [2:0] code;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic       e_none;
        logic [3:0] e_y;
        logic       e_err;
        logic [7:0] e_dec;
    } vec_t;

    vec_t vecs[$];

    priority_decoder_seq #(
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pcode     (pcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_none    (y_none),
        .err       (err),
`ifdef PDEC_ERR_CNT_EN
        .err_cnt   (err_cnt),
`endif
        .dec_cnt   (dec_cnt)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [2:0] code, input logic ordy);
        in_valid  = iv;
        pcode     = code;
        out_ready = ordy;
    endtask

    task automatic checkVal(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s step=%0d got=%0h want=%0h", name, idx, got, want);
        end
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        checkVal("in_ready",  idx, 8'(in_ready),  8'(v.e_ir));
        checkVal("out_valid", idx, 8'(out_valid), 8'(v.e_ov));
        checkVal("y_none",    idx, 8'(y_none),    8'(v.e_none));
        checkVal("y",         idx, 8'(y),         8'(v.e_y));
        checkVal("err",       idx, 8'(err),       8'(v.e_err));
        checkVal("dec_cnt",   idx, dec_cnt,       v.e_dec);
    endtask

    task automatic addVec(input logic iv, input logic [2:0] code, input logic ordy,
                          input logic ir, input logic ov, input logic none,
                          input logic [3:0] ey, input logic eerr, input logic [7:0] edec);
        vec_t v;
        v.iv = iv; v.code = code; v.ordy = ordy;
        v.e_ir = ir; v.e_ov = ov; v.e_none = none;
        v.e_y = ey; v.e_err = eerr; v.e_dec = edec;
        vecs.push_back(v);
    endtask

    // Reset then release; leaves the DUT in its first RUN cycle.
    task automatic resetAndRelease(input int tag);
        rst = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0);
        step();
        step();
        checkVal("rst_out_valid", tag, 8'(out_valid), 8'd0);
        checkVal("rst_in_ready",  tag, 8'(in_ready),  8'd0);
        checkVal("rst_y",         tag, 8'(y),         8'd0);
        checkVal("rst_y_none",    tag, 8'(y_none),    8'd0);
        checkVal("rst_err",       tag, 8'(err),       8'd0);
        checkVal("rst_dec_cnt",   tag, dec_cnt,       8'd0);
`ifdef PDEC_ERR_CNT_EN
        checkVal("rst_err_cnt",   tag, err_cnt,       8'd0);
`endif
        rst = 1'b0;
        checkVal("flush_in_ready", tag, 8'(in_ready), 8'd0);
        step();
        checkVal("run_in_ready",   tag, 8'(in_ready), 8'd1);
        checkVal("run_out_valid",  tag, 8'(out_valid), 8'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0);

        //      iv code or  ir ov none y        err dec
        // codes 0..4 back-to-back, consumer always ready
        addVec(1, 3'd0, 1,  1, 0, 0, 4'b0000, 0, 8'd0);
        addVec(1, 3'd1, 1,  1, 1, 1, 4'b0000, 0, 8'd1);
        addVec(1, 3'd2, 1,  1, 1, 0, 4'b0001, 0, 8'd2);
        addVec(1, 3'd3, 1,  1, 1, 0, 4'b0010, 0, 8'd3);
        addVec(1, 3'd4, 1,  1, 1, 0, 4'b0100, 0, 8'd4);
        addVec(0, 3'd0, 1,  1, 1, 0, 4'b1000, 0, 8'd5);
        addVec(0, 3'd0, 1,  1, 0, 0, 4'b0000, 0, 8'd5);
        // illegal 6 then legal 2: only 0010 comes out
        addVec(1, 3'd6, 1,  1, 0, 0, 4'b0000, 0, 8'd5);
        addVec(1, 3'd2, 1,  1, 0, 0, 4'b0000, 1, 8'd5);
        addVec(0, 3'd0, 1,  1, 1, 0, 4'b0010, 1, 8'd6);
        // boundary illegal code 5 is dropped
        addVec(1, 3'd5, 1,  1, 0, 0, 4'b0000, 1, 8'd6);
        addVec(0, 3'd0, 1,  1, 0, 0, 4'b0000, 1, 8'd6);
        // stall consumer, fill buffer with 3 and 4, hold head
        addVec(1, 3'd3, 0,  1, 0, 0, 4'b0000, 1, 8'd6);
        addVec(1, 3'd4, 0,  1, 1, 0, 4'b0100, 1, 8'd7);
        addVec(0, 3'd0, 0,  0, 1, 0, 4'b0100, 1, 8'd8);
        addVec(0, 3'd0, 0,  0, 1, 0, 4'b0100, 1, 8'd8);
        addVec(0, 3'd0, 0,  0, 1, 0, 4'b0100, 1, 8'd8);
        addVec(1, 3'd1, 0,  0, 1, 0, 4'b0100, 1, 8'd8);
        // full with consumer ready: no accept this cycle, one pop
        addVec(1, 3'd1, 1,  0, 1, 0, 4'b0100, 1, 8'd8);
        addVec(1, 3'd1, 1,  1, 1, 0, 4'b1000, 1, 8'd8);
        addVec(0, 3'd0, 1,  1, 1, 0, 4'b0001, 1, 8'd9);
        addVec(0, 3'd0, 0,  1, 0, 0, 4'b0000, 1, 8'd9);
        // queue two entries ahead of a mid-operation reset
        addVec(1, 3'd0, 0,  1, 0, 0, 4'b0000, 1, 8'd9);
        addVec(1, 3'd2, 0,  1, 1, 1, 4'b0000, 1, 8'd10);
        addVec(0, 3'd0, 0,  0, 1, 1, 4'b0000, 1, 8'd11);

        resetAndRelease(1000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].iv, vecs[i].code, vecs[i].ordy);
            checkOutput(i, vecs[i]);
            step();
        end

        // Reset with two entries queued: everything is discarded.
        rst = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b1);
        step();
        checkVal("mid_rst_out_valid", 2000, 8'(out_valid), 8'd0);
        checkVal("mid_rst_err",       2000, 8'(err),       8'd0);
        checkVal("mid_rst_dec_cnt",   2000, dec_cnt,       8'd0);
        checkVal("mid_rst_in_ready",  2000, 8'(in_ready),  8'd0);
        rst = 1'b0;
        checkVal("mid_rel1_in_ready", 2001, 8'(in_ready),  8'd0);
        step();
        checkVal("mid_rel2_in_ready", 2002, 8'(in_ready),  8'd1);
        checkVal("mid_rel2_out_valid", 2002, 8'(out_valid), 8'd0);
        step();
        checkVal("mid_rel3_out_valid", 2003, 8'(out_valid), 8'd0);

`ifdef PDEC_ERR_CNT_EN
        // 300 illegal code-7 inputs: counter saturates at 255.
        resetAndRelease(3000);
        applyStimulus(1'b1, 3'd7, 1'b1);
        step();
        checkVal("err_cnt_first", 3001, err_cnt, 8'd1);
        checkVal("err_first",     3001, 8'(err), 8'd1);
        for (int i = 1; i < 300; i++) begin
            step();
        end
        applyStimulus(1'b0, 3'd0, 1'b1);
        checkVal("err_cnt_sat",   3002, err_cnt,        8'd255);
        checkVal("err_sat",       3002, 8'(err),        8'd1);
        checkVal("sat_out_valid", 3002, 8'(out_valid),  8'd0);
        checkVal("sat_dec_cnt",   3002, dec_cnt,        8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
